riscv_fetch_stage: RTL and testbench
====================================

Name: riscv_fetch_stage

Overview:
- Instruction-fetch stage of the RISC_V core: owns the program counter, drives the address of the asynchronous instruction memory, and loads the IF/ID pipeline register consumed by decode.
- Handles stall from the hazard unit, redirect/flush from the branch unit, and a post-reset boot hold.
- Exposes a saturating fetch counter and a sticky misalignment flag for the bench checkers.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset (text segment base)
BOOT_CYCLES, 2, cycles after reset release before the first fetch is committed (1..15)
NOP_INSTR, 32'h00000013, instruction injected into IF/ID on flush (addi x0,x0,0)
CNT_W, 16, width of FETCH_CNT

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  reset, synchronous, active-low
STALL  in  1  hold PC and IF/ID this cycle
BRANCH_TAKEN  in  1  redirect PC and flush IF/ID
BRANCH_TARGET  in  32  redirect address
INSTR  in  32  instruction word from instruction memory (combinational w.r.t. INSTR_ADDR)
INSTR_ADDR  out  32  current PC to instruction memory
IFID_PC  out  32  PC of instruction held in IF/ID
IFID_INSTR  out  32  instruction held in IF/ID
IFID_VALID  out  1  IF/ID holds a real instruction
FETCH_CNT  out  CNT_W  number of instructions committed into IF/ID, saturating
MISALIGN  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Reset is sampled only on a rising CLK edge with RSTN=0. It sets pc_q=RESET_PC, IFID_PC=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0, FETCH_CNT=0, MISALIGN=0, boot counter=0, state=S_BOOT.
- Reset asserted mid-operation overrides every other input on that edge.
- INSTR_ADDR = pc_q, combinationally. INSTR is sampled at the same edge that advances the PC, so latency from PC to IF/ID is 1 cycle.
- FSM states:
  - S_BOOT: pc_q holds and IF/ID stays in the reset value. STALL and BRANCH_TAKEN are ignored. The boot counter increments each edge. Go to S_RUN on the edge where counter == BOOT_CYCLES-1.
  - S_RUN: per edge, in priority order:
    1. BRANCH_TAKEN=1: pc_q={BRANCH_TARGET[31:2],2'b00}, IFID_INSTR=NOP_INSTR, IFID_PC=0, IFID_VALID=0, FETCH_CNT unchanged. If BRANCH_TARGET[1:0]!=0, set MISALIGN=1. Branch wins over a simultaneous STALL.
    2. STALL=1: pc_q, IFID_*, FETCH_CNT all hold.
    3. Otherwise: IFID_PC=pc_q, IFID_INSTR=INSTR, IFID_VALID=1, pc_q=pc_q+4, FETCH_CNT=FETCH_CNT+1.
- Arithmetic:
  - PC increment is modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
  - FETCH_CNT saturates at 2^CNT_W-1 and holds there.
- MISALIGN clears only on reset. The redirect still proceeds with the bits forced to zero.
- The state has no path back to S_BOOT other than reset.
- All outputs are registered except INSTR_ADDR.

Test Plan:
1. Reset then release, STALL=0, BRANCH_TAKEN=0, memory word at addr A = A xor 32'hA5A5A5A5 -> INSTR_ADDR=0x00400000 for 2 boot cycles with IFID_VALID=0. On the next edge IFID_PC=0x00400000, IFID_VALID=1, INSTR_ADDR=0x00400004, FETCH_CNT=1.
2. In S_RUN, STALL=1 for 3 cycles at PC 0x00400008 -> INSTR_ADDR, IFID_PC=0x00400004, and FETCH_CNT=2 are all constant for 3 cycles. Fetch resumes at 0x00400008 once STALL drops.
3. BRANCH_TAKEN=1 and STALL=1 together, target 0x00400040 -> next cycle INSTR_ADDR=0x00400040, IFID_INSTR=0x00000013, IFID_VALID=0. The following fetch gives IFID_PC=0x00400040.
4. Redirect to 0x00400046 -> INSTR_ADDR=0x00400044 and MISALIGN=1. MISALIGN stays 1 through 10 further fetches and clears only after reset.
5. Redirect to 0xFFFFFFFC, then 2 fetches -> IFID_PC=0xFFFFFFFC then 0x00000000, INSTR_ADDR=0x00000004.
6. Assert RSTN=0 for one edge mid-run with STALL=1 and BRANCH_TAKEN=1 -> all outputs return to reset values and the 2-cycle boot hold repeats. With CNT_W=4, 20 fetches leave FETCH_CNT at 15.

Source files
------------

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous instruction
// memory and loads the IF/ID register. A short boot hold follows reset, then
// redirects (with flush) take priority over stalls, which take priority over fetch.
module riscv_fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h00400000,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter logic [31:0] NOP_INSTR   = 32'h00000013,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             STALL,
   input  logic             BRANCH_TAKEN,
   input  logic [31:0]      BRANCH_TARGET,
   input  logic [31:0]      INSTR,
   output logic [31:0]      INSTR_ADDR,
   output logic [31:0]      IFID_PC,
   output logic [31:0]      IFID_INSTR,
   output logic             IFID_VALID,
   output logic [CNT_W-1:0] FETCH_CNT,
   output logic             MISALIGN
);

   typedef enum logic [0:0] {StBoot, StRun} state_e;

   // Boot counter value on the edge that leaves the boot hold.
   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_e             state_q, state_d;
   logic [3:0]         boot_cnt_q, boot_cnt_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        ifid_pc_q, ifid_pc_d;
   logic [31:0]        ifid_instr_q, ifid_instr_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
   logic               misalign_q, misalign_d;

   // Next-state: boot hold, then redirect > stall > sequential fetch.
   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      fetch_cnt_d  = fetch_cnt_q;
      misalign_d   = misalign_q;
      unique case (state_q)
         StBoot: begin
            boot_cnt_d = boot_cnt_q + 4'd1;
            if (boot_cnt_q == BOOT_LAST) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (BRANCH_TAKEN) begin
               // Low bits are dropped; a misaligned target is only flagged.
               pc_d         = {BRANCH_TARGET[31:2], 2'b00};
               ifid_pc_d    = 32'h0;
               ifid_instr_d = NOP_INSTR;
               ifid_valid_d = 1'b0;
               if (BRANCH_TARGET[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end
            end else if (!STALL) begin
               ifid_pc_d    = pc_q;
               ifid_instr_d = INSTR;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
               if (fetch_cnt_q != {CNT_W{1'b1}}) begin
                  fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = StBoot;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q      <= StBoot;
         boot_cnt_q   <= 4'd0;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 32'h0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         fetch_cnt_q  <= '0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         fetch_cnt_q  <= fetch_cnt_d;
         misalign_q   <= misalign_d;
      end
   end

   // Output mapping: only the memory address is combinational.
   always_comb begin
      INSTR_ADDR = pc_q;
      IFID_PC    = ifid_pc_q;
      IFID_INSTR = ifid_instr_q;
      IFID_VALID = ifid_valid_q;
      FETCH_CNT  = fetch_cnt_q;
      MISALIGN   = misalign_q;
   end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: directed scenarios followed by random traffic.
// A reference model predicts the post-edge outputs; a monitor compares them.
module tb_riscv_fetch_stage;

   localparam int unsigned CNT_W   = 4;
   localparam logic [31:0] MEM_KEY = 32'hA5A5A5A5;
   localparam logic [31:0] NOP     = 32'h00000013;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             RSTN = 1'b0;
   logic             STALL = 1'b0;
   logic             BRANCH_TAKEN = 1'b0;
   logic [31:0]      BRANCH_TARGET = 32'h0;
   logic [31:0]      INSTR;
   logic [31:0]      INSTR_ADDR;
   logic [31:0]      IFID_PC;
   logic [31:0]      IFID_INSTR;
   logic             IFID_VALID;
   logic [CNT_W-1:0] FETCH_CNT;
   logic             MISALIGN;

   riscv_fetch_stage #(
      .RESET_PC    (32'h00400000),
      .BOOT_CYCLES (2),
      .NOP_INSTR   (NOP),
      .CNT_W       (CNT_W)
   ) dut (
      .CLK           (CLK),
      .RSTN          (RSTN),
      .STALL         (STALL),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .BRANCH_TARGET (BRANCH_TARGET),
      .INSTR         (INSTR),
      .INSTR_ADDR    (INSTR_ADDR),
      .IFID_PC       (IFID_PC),
      .IFID_INSTR    (IFID_INSTR),
      .IFID_VALID    (IFID_VALID),
      .FETCH_CNT     (FETCH_CNT),
      .MISALIGN      (MISALIGN)
   );

   always #5 CLK = ~CLK;

   // Instruction memory: word at address A is A xor key.
   assign INSTR = INSTR_ADDR ^ MEM_KEY;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] ifid_pc;
      logic [31:0] ifid_instr;
      logic        valid;
      int unsigned cnt;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state.
   logic [31:0] m_pc = 32'h00400000;
   logic [31:0] m_ifid_pc = 32'h0;
   logic [31:0] m_ifid_instr = NOP;
   logic        m_valid = 1'b0;
   int unsigned m_cnt = 0;
   logic        m_mis = 1'b0;
   int unsigned m_boot_left = 2;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs and push the predicted outputs after the edge.
   task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
      exp_t e;
      @(negedge CLK);
      RSTN = r;
      STALL = s;
      BRANCH_TAKEN = b;
      BRANCH_TARGET = t;
      if (!r) begin
         m_pc = 32'h00400000; m_ifid_pc = 32'h0; m_ifid_instr = NOP;
         m_valid = 1'b0; m_cnt = 0; m_mis = 1'b0; m_boot_left = 2;
      end else if (m_boot_left > 0) begin
         m_boot_left--;
      end else if (b) begin
         m_pc = t & 32'hFFFFFFFC;
         m_ifid_pc = 32'h0;
         m_ifid_instr = NOP;
         m_valid = 1'b0;
         if (t % 4 != 0) m_mis = 1'b1;
      end else if (!s) begin
         m_ifid_pc = m_pc;
         m_ifid_instr = m_pc ^ MEM_KEY;
         m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
         if (m_cnt < CNT_MAX) m_cnt++;
      end
      e.addr = m_pc; e.ifid_pc = m_ifid_pc; e.ifid_instr = m_ifid_instr;
      e.valid = m_valid; e.cnt = m_cnt; e.mis = m_mis;
      exp_q.push_back(e);
   endtask

   task automatic fetch(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   // Wait for the edge that consumes the last step, then sample.
   task automatic settle();
      @(posedge CLK);
      #2;
   endtask

   // Monitor: after every edge, compare DUT outputs with the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr_addr", INSTR_ADDR, e.addr);
            check("ifid_pc", IFID_PC, e.ifid_pc);
            check("ifid_instr", IFID_INSTR, e.ifid_instr);
            check("ifid_valid", {31'h0, IFID_VALID}, {31'h0, e.valid});
            check("fetch_cnt", {28'h0, FETCH_CNT}, e.cnt);
            check("misalign", {31'h0, MISALIGN}, {31'h0, e.mis});
         end
      end
   end

   initial begin
      // Boot hold and first fetch.
      step(1'b0, 1'b1, 1'b1, 32'h00400040);
      fetch(2);
      settle();
      check("boot_valid", {31'h0, IFID_VALID}, 32'h0);
      check("boot_addr", INSTR_ADDR, 32'h00400000);
      fetch(1);
      settle();
      check("first_ifid_pc", IFID_PC, 32'h00400000);
      check("first_addr", INSTR_ADDR, 32'h00400004);
      check("first_cnt", {28'h0, FETCH_CNT}, 32'd1);

      // Stall holds everything.
      fetch(1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      settle();
      check("stall_addr", INSTR_ADDR, 32'h00400008);
      check("stall_ifid_pc", IFID_PC, 32'h00400004);
      check("stall_cnt", {28'h0, FETCH_CNT}, 32'd2);
      fetch(1);
      settle();
      check("resume_ifid_pc", IFID_PC, 32'h00400008);

      // Branch beats stall.
      step(1'b1, 1'b1, 1'b1, 32'h00400040);
      settle();
      check("br_addr", INSTR_ADDR, 32'h00400040);
      check("br_flush_instr", IFID_INSTR, NOP);
      fetch(1);
      settle();
      check("br_ifid_pc", IFID_PC, 32'h00400040);

      // Misaligned redirect sticks.
      step(1'b1, 1'b0, 1'b1, 32'h00400046);
      settle();
      check("mis_addr", INSTR_ADDR, 32'h00400044);
      check("mis_set", {31'h0, MISALIGN}, 32'h1);
      fetch(10);

      // PC wrap.
      step(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
      fetch(1);
      settle();
      check("wrap_ifid_pc0", IFID_PC, 32'hFFFFFFFC);
      fetch(1);
      settle();
      check("wrap_ifid_pc1", IFID_PC, 32'h00000000);
      check("wrap_addr", INSTR_ADDR, 32'h00000004);

      // Reset wins over stall and branch; then saturate the counter.
      step(1'b0, 1'b1, 1'b1, 32'h00000123);
      settle();
      check("rst_mis", {31'h0, MISALIGN}, 32'h0);
      check("rst_cnt", {28'h0, FETCH_CNT}, 32'h0);
      fetch(22);
      settle();
      check("sat_cnt", {28'h0, FETCH_CNT}, CNT_MAX);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         tgt = $urandom();
         if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
         step(($urandom_range(39) != 0), ($urandom_range(3) == 0),
              ($urandom_range(5) == 0), tgt);
      end

      repeat (2) @(posedge CLK);
      #3;
      check("queue_drained", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
